// File: rtl/uart_alu_ctrl.sv
// -----------------------------------------------------------------------------
// uart_alu_ctrl
// Frame controller sitting between uart_rx, a combinational ALU and uart_tx.
// Three received bytes form a frame: operand A, operand B, opcode. The bytes
// are held as registered ALU inputs. The ALU result is latched and sent with a
// single transmit request. The block then re-arms for the next frame.
// An inter-byte timeout throws away incomplete frames and pulses o_error.
//
// Ports
//   i_clock      : single clock
//   i_reset      : synchronous, active-high reset
//   i_rx_data    : received byte from uart_rx
//   i_rx_done    : uart_rx done flag (pulse or level, rising edge counts)
//   i_alu_result : combinational ALU result for o_alu_a/o_alu_b/o_alu_op
//   i_tx_done    : uart_tx completion pulse
//   o_alu_a      : registered operand A
//   o_alu_b      : registered operand B
//   o_alu_op     : registered opcode (low NB_OP bits of the third byte)
//   o_tx_data    : byte to transmit, held from o_tx_start until i_tx_done
//   o_tx_start   : one-cycle transmit request
//   o_busy       : high while executing or waiting for the transmitter
//   o_error      : one-cycle pulse when a frame times out
// -----------------------------------------------------------------------------
module uart_alu_ctrl #(
   parameter int NB_DATA  = 8,
   parameter int NB_OP    = 6,
   parameter int TIMEOUT  = 1000000,
   parameter int NB_TIMER = 20
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   input  logic [NB_DATA-1:0] i_alu_result,
   input  logic               i_tx_done,
   output logic [NB_DATA-1:0] o_alu_a,
   output logic [NB_DATA-1:0] o_alu_b,
   output logic [NB_OP-1:0]   o_alu_op,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy,
   output logic               o_error
);

   typedef enum logic [2:0] {
      S_OPA     = 3'd0,
      S_OPB     = 3'd1,
      S_OPCODE  = 3'd2,
      S_EXEC    = 3'd3,
      S_WAIT_TX = 3'd4
   } state_t;

   // Timer value in the cycle where a frame gives up waiting for its next byte.
   localparam logic [NB_TIMER-1:0] TIMER_LAST = NB_TIMER'(TIMEOUT - 1);
   localparam logic [NB_TIMER-1:0] TIMER_ONE  = NB_TIMER'(1);
   localparam logic [NB_TIMER-1:0] TIMER_ZERO = NB_TIMER'(0);

   state_t              state_r;
   state_t              next_state_s;
   logic                rx_done_q_r;
   logic                rx_rise_s;
   logic [NB_TIMER-1:0] timer_r;
   logic                timer_inc_s;
   logic                timeout_s;
   logic                load_a_s;
   logic                load_b_s;
   logic                load_op_s;
   logic                exec_s;
   logic [NB_DATA-1:0]  alu_a_r;
   logic [NB_DATA-1:0]  alu_b_r;
   logic [NB_OP-1:0]    alu_op_r;
   logic [NB_DATA-1:0]  tx_data_r;
   logic                tx_start_r;
   logic                busy_r;
   logic                error_r;

   // A level held for many cycles counts as one byte; only the rising edge matters.
   assign rx_rise_s = i_rx_done & ~rx_done_q_r;

   // State register.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_r <= S_OPA;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and datapath control decode.
   always_comb begin
      next_state_s = state_r;
      timer_inc_s  = 1'b0;
      timeout_s    = 1'b0;
      load_a_s     = 1'b0;
      load_b_s     = 1'b0;
      load_op_s    = 1'b0;
      exec_s       = 1'b0;
      case (state_r)
         S_OPA: begin
            if (rx_rise_s) begin
               load_a_s     = 1'b1;
               next_state_s = S_OPB;
            end else begin
               next_state_s = S_OPA;
            end
         end
         S_OPB: begin
            // A byte arriving in the timeout cycle takes priority over the timeout.
            if (rx_rise_s) begin
               load_b_s     = 1'b1;
               next_state_s = S_OPCODE;
            end else if (timer_r == TIMER_LAST) begin
               timeout_s    = 1'b1;
               next_state_s = S_OPA;
            end else begin
               timer_inc_s  = 1'b1;
            end
         end
         S_OPCODE: begin
            if (rx_rise_s) begin
               load_op_s    = 1'b1;
               next_state_s = S_EXEC;
            end else if (timer_r == TIMER_LAST) begin
               timeout_s    = 1'b1;
               next_state_s = S_OPA;
            end else begin
               timer_inc_s  = 1'b1;
            end
         end
         S_EXEC: begin
            // The ALU inputs have been stable for a full cycle here.
            exec_s       = 1'b1;
            next_state_s = S_WAIT_TX;
         end
         S_WAIT_TX: begin
            if (i_tx_done) begin
               next_state_s = S_OPA;
            end else begin
               next_state_s = S_WAIT_TX;
            end
         end
         default: begin
            next_state_s = S_OPA;
         end
      endcase
   end

   // Edge detector, inter-byte timer and registered outputs.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         rx_done_q_r <= 1'b0;
         timer_r     <= TIMER_ZERO;
         alu_a_r     <= {NB_DATA{1'b0}};
         alu_b_r     <= {NB_DATA{1'b0}};
         alu_op_r    <= {NB_OP{1'b0}};
         tx_data_r   <= {NB_DATA{1'b0}};
         tx_start_r  <= 1'b0;
         busy_r      <= 1'b0;
         error_r     <= 1'b0;
      end else begin
         // Tracks in every state so a level spanning S_WAIT_TX is not re-counted.
         rx_done_q_r <= i_rx_done;
         timer_r     <= timer_inc_s ? (timer_r + TIMER_ONE) : TIMER_ZERO;
         if (load_a_s) begin
            alu_a_r <= i_rx_data;
         end
         if (load_b_s) begin
            alu_b_r <= i_rx_data;
         end
         if (load_op_s) begin
            alu_op_r <= i_rx_data[NB_OP-1:0];
         end
         if (exec_s) begin
            tx_data_r <= i_alu_result;
         end
         tx_start_r  <= exec_s;
         // Registered from the next state so o_busy lines up with the state.
         busy_r      <= (next_state_s == S_EXEC) || (next_state_s == S_WAIT_TX);
         error_r     <= timeout_s;
      end
   end

   assign o_alu_a    = alu_a_r;
   assign o_alu_b    = alu_b_r;
   assign o_alu_op   = alu_op_r;
   assign o_tx_data  = tx_data_r;
   assign o_tx_start = tx_start_r;
   assign o_busy     = busy_r;
   assign o_error    = error_r;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_ctrl
// Scoreboard bench for uart_alu_ctrl. A byte-level reference model predicts
// captures, transmit results/cycles, timeout pulses and the busy window from
// the arrival cycle of each byte. A monitor compares the DUT against those
// predictions on the falling clock edge. A small ALU model and a uart_tx
// responder complete the environment.
// -----------------------------------------------------------------------------
module tb_uart_alu_ctrl;

   localparam int NB_DATA  = 8;
   localparam int NB_OP    = 6;
   localparam int TIMEOUT  = 20;
   localparam int NB_TIMER = 20;
   localparam int INT_MAX  = 2147483647;

   typedef struct {
      int         which;
      logic [7:0] val;
      int         cyc;
   } cap_t;

   typedef struct {
      logic [7:0] val;
      int         cyc;
   } tx_t;

   logic       clock_tb_i = 1'b0;
   logic       reset_tb   = 1'b1;
   logic [7:0] rx_data_tb = 8'h00;
   logic       rx_done_tb = 1'b0;
   logic       tx_done_tb = 1'b0;
   logic [7:0] alu_result_tb;
   logic [7:0] dut_alu_a;
   logic [7:0] dut_alu_b;
   logic [5:0] dut_alu_op;
   logic [7:0] dut_tx_data;
   logic       dut_tx_start;
   logic       dut_busy;
   logic       dut_error;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit mon_en   = 1'b0;

   // Reference model state
   cap_t       cap_q[$];
   tx_t        tx_q[$];
   int         err_q[$];
   int         phase      = 0;
   int         last_n     = 0;
   logic [7:0] ma         = 8'h00;
   logic [7:0] mb         = 8'h00;
   bit         mbusy      = 1'b0;
   int         busy_start = 0;
   int         busy_end   = INT_MAX;
   int         gen        = 0;
   int         tx_delay   = 2;

   string cap_names [7] = '{"alu_a", "alu_b", "alu_op", "tx_data", "tx_start", "busy", "error"};
   logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

   always #5 clock_tb_i = ~clock_tb_i;

   always @(posedge clock_tb_i) cyc <= cyc + 1;

   function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h27:   return ~(a | b);
         6'h02:   return a >> b;
         6'h03:   return $signed(a) >>> b;
         default: return 8'h00;
      endcase
   endfunction

   assign alu_result_tb = alu_ref(dut_alu_a, dut_alu_b, dut_alu_op);

   uart_alu_ctrl #(
      .NB_DATA  (NB_DATA),
      .NB_OP    (NB_OP),
      .TIMEOUT  (TIMEOUT),
      .NB_TIMER (NB_TIMER)
   ) dut (
      .i_clock      (clock_tb_i),
      .i_reset      (reset_tb),
      .i_rx_data    (rx_data_tb),
      .i_rx_done    (rx_done_tb),
      .i_alu_result (alu_result_tb),
      .i_tx_done    (tx_done_tb),
      .o_alu_a      (dut_alu_a),
      .o_alu_b      (dut_alu_b),
      .o_alu_op     (dut_alu_op),
      .o_tx_data    (dut_tx_data),
      .o_tx_start   (dut_tx_start),
      .o_busy       (dut_busy),
      .o_error      (dut_error)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_cap(input int which, input logic [7:0] v, input int c);
      cap_t e;
      e.which = which;
      e.val   = v;
      e.cyc   = c;
      cap_q.push_back(e);
   endtask

   // Byte whose rise is in cycle n: decide what the controller does with it.
   task automatic model_accept(input logic [7:0] b, input int n);
      tx_t t;
      if (mbusy && n > busy_end) mbusy = 1'b0;
      if (mbusy) begin
         // Dropped: operands must not move.
         push_cap(0, ma, n + 1);
         push_cap(1, mb, n + 1);
      end else begin
         if (phase != 0) begin
            if (n - last_n > TIMEOUT) phase = 0;               // frame already timed out
            else if (err_q.size() > 0) void'(err_q.pop_back()); // byte in time, no timeout
         end
         case (phase)
            0: begin
               ma = b;
               push_cap(0, b, n + 1);
               phase = 1;
               err_q.push_back(n + TIMEOUT + 1);
            end
            1: begin
               mb = b;
               push_cap(1, b, n + 1);
               phase = 2;
               err_q.push_back(n + TIMEOUT + 1);
            end
            default: begin
               push_cap(2, {2'b00, b[5:0]}, n + 1);
               phase      = 0;
               mbusy      = 1'b1;
               busy_start = n;
               busy_end   = INT_MAX;
               t.val      = alu_ref(ma, mb, b[5:0]);
               t.cyc      = n + 2;
               tx_q.push_back(t);
            end
         endcase
         last_n = n;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
      @(posedge clock_tb_i);
      #1;
      model_accept(b, cyc);
      rx_data_tb = b;
      rx_done_tb = 1'b1;
      repeat (hold) @(posedge clock_tb_i);
      #1;
      rx_done_tb = 1'b0;
      repeat (gap) @(posedge clock_tb_i);
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input int hold, input int gap);
      send_byte(a, hold, gap);
      send_byte(b, hold, gap);
      send_byte(op, hold, gap);
   endtask

   task automatic do_reset();
      @(posedge clock_tb_i);
      #1;
      reset_tb   = 1'b1;
      rx_done_tb = 1'b0;
      @(posedge clock_tb_i);
      #1;
      reset_tb = 1'b0;
      gen++;
      phase = 0;
      mbusy = 1'b0;
      ma    = 8'h00;
      mb    = 8'h00;
      tx_q.delete();
      err_q.delete();
      cap_q.delete();
      for (int i = 0; i < 7; i++) push_cap(i, 8'h00, cyc);
      mon_en = 1'b1;
   endtask

   // uart_tx stand-in: completes a transmit tx_delay cycles after the request.
   initial begin : responder
      int g;
      int d;
      forever begin
         @(negedge clock_tb_i);
         if (dut_tx_start === 1'b1) begin
            g = gen;
            d = tx_delay;
            @(posedge clock_tb_i);
            #2;
            for (int i = 0; i < d && gen == g; i++) begin
               @(posedge clock_tb_i);
               #2;
            end
            if (gen == g) begin
               tx_done_tb = 1'b1;
               busy_end   = cyc;
               @(posedge clock_tb_i);
               #2;
               tx_done_tb = 1'b0;
            end else begin
               tx_done_tb = 1'b0;
            end
         end
      end
   end

   // Monitor: compares DUT outputs with the scoreboard each falling edge.
   initial begin : monitor
      tx_t        t;
      cap_t       c;
      logic       exp_err;
      logic       exp_busy;
      logic [7:0] act;
      forever begin
         @(negedge clock_tb_i);
         if (mon_en) begin
            if (tx_q.size() > 0 && (dut_tx_start === 1'b1 || tx_q[0].cyc <= cyc)) begin
               t = tx_q.pop_front();
               check("tx_start", {31'd0, dut_tx_start}, 32'd1);
               check("tx_cycle", cyc, t.cyc);
               check("tx_data", {24'd0, dut_tx_data}, {24'd0, t.val});
            end else begin
               check("tx_start_idle", {31'd0, dut_tx_start}, 32'd0);
            end
            exp_err = 1'b0;
            while (err_q.size() > 0 && err_q[0] <= cyc) begin
               if (err_q[0] == cyc) exp_err = 1'b1;
               void'(err_q.pop_front());
            end
            check("error", {31'd0, dut_error}, {31'd0, exp_err});
            exp_busy = mbusy && (cyc > busy_start) && (cyc <= busy_end);
            check("busy", {31'd0, dut_busy}, {31'd0, exp_busy});
            while (cap_q.size() > 0 && cap_q[0].cyc <= cyc) begin
               c = cap_q.pop_front();
               case (c.which)
                  0:       act = dut_alu_a;
                  1:       act = dut_alu_b;
                  2:       act = {2'b00, dut_alu_op};
                  3:       act = dut_tx_data;
                  4:       act = {7'd0, dut_tx_start};
                  5:       act = {7'd0, dut_busy};
                  6:       act = {7'd0, dut_error};
                  default: act = 8'h00;
               endcase
               check(cap_names[c.which], {24'd0, act}, {24'd0, c.val});
            end
         end
      end
   end

   // Stimulus
   initial begin : stim
      logic [7:0] ob;
      int         r;
      do_reset();

      // Normal ADD, short pulses with wide gaps
      tx_delay = 3;
      send_frame(8'h05, 8'h03, 8'h20, 1, 16);
      // Level-held done flag, AND
      send_frame(8'hF0, 8'h0F, 8'h24, 15, 2);
      repeat (10) @(posedge clock_tb_i);
      // Timeout after operand A, then a good frame
      send_byte(8'h11, 1, 30);
      send_frame(8'h01, 8'h02, 8'h20, 1, 3);
      repeat (10) @(posedge clock_tb_i);
      // Byte exactly in the timeout cycle wins
      send_byte(8'h0A, 1, 3);
      send_byte(8'h0B, 1, 18);
      send_byte(8'h20, 1, 12);
      // One cycle later the frame has already timed out
      send_byte(8'h07, 1, 3);
      send_byte(8'h08, 1, 19);
      send_frame(8'h09, 8'h04, 8'h22, 1, 3);
      repeat (10) @(posedge clock_tb_i);
      // Byte dropped while waiting for the transmitter
      tx_delay = 30;
      send_frame(8'h10, 8'h20, 8'h25, 1, 3);
      send_byte(8'h55, 1, 40);
      tx_delay = 2;
      send_frame(8'h02, 8'h01, 8'h22, 1, 3);
      repeat (10) @(posedge clock_tb_i);
      // Reset after operand B, then a full frame
      send_byte(8'h33, 1, 2);
      send_byte(8'h44, 1, 2);
      do_reset();
      send_frame(8'h06, 8'h07, 8'h26, 2, 2);
      repeat (10) @(posedge clock_tb_i);
      // Reset during S_WAIT_TX, then a full frame
      tx_delay = 30;
      send_frame(8'h81, 8'h02, 8'h03, 1, 2);
      repeat (6) @(posedge clock_tb_i);
      do_reset();
      tx_delay = 1;
      send_frame(8'hC3, 8'h3C, 8'h27, 1, 2);
      repeat (10) @(posedge clock_tb_i);

      // Randomized traffic
      for (int f = 0; f < 60; f++) begin
         tx_delay = $urandom_range(0, 5);
         for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
               ob[5:0] = ops[$urandom_range(0, 7)];
               ob[7:6] = 2'($urandom_range(0, 3));
            end else begin
               ob = 8'($urandom);
            end
            r = $urandom_range(0, 9);
            send_byte(ob, $urandom_range(1, 15), (r == 0) ? $urandom_range(17, 22) : $urandom_range(0, 4));
         end
         if (f % 17 == 9) do_reset();
      end

      repeat (TIMEOUT + 40) @(posedge clock_tb_i);
      #1;
      check("tx_queue_drained", tx_q.size(), 32'd0);
      check("err_queue_drained", err_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
